// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage:
// FSM state encoding, reset PC default and jump-target field positions.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_VALID = 2'd1,
        S_HALT  = 2'd2
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // J-type instr_index field and the PC segment it is spliced into
    localparam int JT_MSB  = 25;
    localparam int JT_LSB  = 0;
    localparam int JT_W    = JT_MSB - JT_LSB + 1;
    localparam int SEG_MSB = 31;
    localparam int SEG_LSB = 28;

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational next-PC select: jr > jmp/jal > taken branch > pc+4.
// In: controls, zero, addr_result, read_data_1, instr_index, opcplus4.
// Out: next_pc (32b), misalign (next_pc[1:0] != 0).
module fetch_next_pc
    import fetch_pkg::*;
(
    input  logic            branch,
    input  logic            nbranch,
    input  logic            jmp,
    input  logic            jal,
    input  logic            jr,
    input  logic            zero,
    input  logic [31:0]     addr_result,
    input  logic [31:0]     read_data_1,
    input  logic [JT_W-1:0] instr_index,
    input  logic [31:0]     opcplus4,
    output logic [31:0]     next_pc,
    output logic            misalign
);

    logic taken;

    assign taken = (branch & zero) | (nbranch & ~zero);

    always_comb begin
        next_pc = opcplus4;
        if (jr) begin
            next_pc = read_data_1;
        end else if (jmp | jal) begin
            next_pc = {opcplus4[SEG_MSB:SEG_LSB], instr_index, 2'b00};
        end else if (taken) begin
            next_pc = addr_result;
        end
        misalign = |next_pc[1:0];
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: holds the PC, fetches one word per instruction
// over imem req/ready, presents Instruction/opcplus4 to decode and
// selects the next PC on advance. Misaligned targets halt with fault set.
// Ports: clock/reset, imem_req/addr/ready/rdata, Instruction, opcplus4,
// instr_valid, advance, Branch/nBranch/Jmp/Jal/Jr, Zero, Addr_result,
// Read_data_1, fault.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          ADDR_W   = 14
) (
    input  logic              clock,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       Instruction,
    output logic [31:0]       opcplus4,
    output logic              instr_valid,
    input  logic              advance,
    input  logic              Branch,
    input  logic              nBranch,
    input  logic              Jmp,
    input  logic              Jal,
    input  logic              Jr,
    input  logic              Zero,
    input  logic [31:0]       Addr_result,
    input  logic [31:0]       Read_data_1,
    output logic              fault
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  opc4_q, opc4_d;
    logic         valid_q, valid_d;
    logic         fault_q, fault_d;

    logic [31:0]  next_pc;
    logic         misalign;

    fetch_next_pc u_next_pc (
        .branch      (Branch),
        .nbranch     (nBranch),
        .jmp         (Jmp),
        .jal         (Jal),
        .jr          (Jr),
        .zero        (Zero),
        .addr_result (Addr_result),
        .read_data_1 (Read_data_1),
        .instr_index (instr_q[JT_MSB:JT_LSB]),
        .opcplus4    (opc4_q),
        .next_pc     (next_pc),
        .misalign    (misalign)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        opc4_d  = opc4_q;
        valid_d = valid_q;
        fault_d = fault_q;
        case (state_q)
            S_FETCH: begin
                if (imem_ready) begin
                    instr_d = imem_rdata;
                    opc4_d  = pc_q + 32'd4;
                    valid_d = 1'b1;
                    state_d = S_VALID;
                end
            end
            S_VALID: begin
                if (advance) begin
                    valid_d = 1'b0;
                    if (misalign) begin
                        // PC keeps the faulting instruction's address
                        fault_d = 1'b1;
                        state_d = S_HALT;
                    end else begin
                        pc_d    = next_pc;
                        state_d = S_FETCH;
                    end
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_HALT;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            instr_q <= 32'd0;
            opc4_q  <= 32'd0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            opc4_q  <= opc4_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
        end
    end

    // Request is held off while reset is asserted so memory never sees
    // a fetch during the reset cycle.
    assign imem_req    = (state_q == S_FETCH) & ~reset;
    assign imem_addr   = pc_q[ADDR_W+1:2];
    assign Instruction = instr_q;
    assign opcplus4    = opc4_q;
    assign instr_valid = valid_q;
    assign fault       = fault_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: memory model with wait states,
// expected fetch results queued at request time and checked on valid.
module tb_instr_fetch;

    logic        clock = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [13:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] Instruction;
    logic [31:0] opcplus4;
    logic        instr_valid;
    logic        advance;
    logic        Branch, nBranch, Jmp, Jal, Jr, Zero;
    logic [31:0] Addr_result;
    logic [31:0] Read_data_1;
    logic        fault;

    instr_fetch #(.RESET_PC(32'h0), .ADDR_W(14)) dut (
        .clock       (clock),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .Instruction (Instruction),
        .opcplus4    (opcplus4),
        .instr_valid (instr_valid),
        .advance     (advance),
        .Branch      (Branch),
        .nBranch     (nBranch),
        .Jmp         (Jmp),
        .Jal         (Jal),
        .Jr          (Jr),
        .Zero        (Zero),
        .Addr_result (Addr_result),
        .Read_data_1 (Read_data_1),
        .fault       (fault)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] opc;
    } exp_t;

    localparam logic [4:0] C_NONE = 5'b00000;
    localparam logic [4:0] C_BR   = 5'b10000;
    localparam logic [4:0] C_NBR  = 5'b01000;
    localparam logic [4:0] C_JMP  = 5'b00100;
    localparam logic [4:0] C_JAL  = 5'b00010;
    localparam logic [4:0] C_JR   = 5'b00001;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] pc_m;
    logic [31:0] cur_opc;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        imem_ready  = 1'b0;
        imem_rdata  = 32'd0;
        advance     = 1'b0;
        {Branch, nBranch, Jmp, Jal, Jr} = C_NONE;
        Zero        = 1'b0;
        Addr_result = 32'd0;
        Read_data_1 = 32'd0;
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clock);
        reset = 1'b1;
        clear_inputs();
        repeat (cycles) @(negedge clock);
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_instr", Instruction, 32'd0);
        check("rst_opc4", opcplus4, 32'd0);
        check("rst_fault", {31'd0, fault}, 32'd0);
        check("rst_addr", {18'd0, imem_addr}, 32'd0);
        reset = 1'b0;
        pc_m  = 32'd0;
        sb.delete();
    endtask

    // Serve one fetch after `waits` not-ready request cycles. While
    // waiting, advance/Jr are driven to show they are ignored.
    task automatic fetch(input int waits, input logic [31:0] word);
        int   seen;
        bit   done;
        exp_t e;
        seen = 0;
        done = 1'b0;
        sb.push_back('{instr: word, opc: pc_m + 32'd4});
        for (int cyc = 0; cyc < 50 && !done; cyc++) begin
            @(negedge clock);
            if (imem_req) begin
                check("fetch_addr", {18'd0, imem_addr}, {18'd0, pc_m[15:2]});
                if (seen == waits) begin
                    imem_ready  = 1'b1;
                    imem_rdata  = word;
                    advance     = 1'b0;
                    Jr          = 1'b0;
                    done        = 1'b1;
                end else begin
                    imem_ready  = 1'b0;
                    imem_rdata  = $urandom;
                    advance     = 1'b1;
                    Jr          = 1'b1;
                    Read_data_1 = 32'h42;
                end
                seen++;
            end
        end
        check("fetch_timeout", {31'd0, done}, 32'd1);
        @(negedge clock);
        clear_inputs();
        check("valid_rise", {31'd0, instr_valid}, 32'd1);
        check("req_low", {31'd0, imem_req}, 32'd0);
        e = sb.pop_front();
        check("instr", Instruction, e.instr);
        check("opc4", opcplus4, e.opc);
        cur_opc = e.opc;
    endtask

    task automatic retire(input logic [4:0] ctl, input logic zero,
                          input logic [31:0] ar, input logic [31:0] rd1,
                          input logic [31:0] exp_pc, input logic exp_fault);
        {Branch, nBranch, Jmp, Jal, Jr} = ctl;
        Zero        = zero;
        Addr_result = ar;
        Read_data_1 = rd1;
        advance     = 1'b1;
        @(negedge clock);
        clear_inputs();
        check("ret_valid", {31'd0, instr_valid}, 32'd0);
        check("ret_opc4_hold", opcplus4, cur_opc);
        check("ret_fault", {31'd0, fault}, {31'd0, exp_fault});
        check("ret_req", {31'd0, imem_req}, {31'd0, ~exp_fault});
        if (!exp_fault) begin
            check("ret_addr", {18'd0, imem_addr}, {18'd0, exp_pc[15:2]});
            pc_m = exp_pc;
        end
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        pc_m    = 32'd0;
        cur_opc = 32'd0;

        // Wait-state fetch, then sequential fetches
        do_reset(2);
        fetch(3, 32'h2008_0005);
        retire(C_NONE, 1'b0, 32'h0, 32'h0, 32'h4, 1'b0);
        fetch(0, 32'h0000_0000);
        retire(C_NONE, 1'b0, 32'h0, 32'h0, 32'h8, 1'b0);
        fetch(0, 32'h0000_0000);
        retire(C_NONE, 1'b0, 32'h0, 32'h0, 32'hC, 1'b0);
        fetch(1, 32'h0000_0000);
        check("seq_opc4", opcplus4, 32'h10);

        // jal and branches
        do_reset(1);
        fetch(0, 32'h0C00_0040);
        retire(C_JAL, 1'b0, 32'h0, 32'h0, 32'h100, 1'b0);
        fetch(0, 32'h0000_0000);
        retire(C_BR, 1'b1, 32'h20, 32'h0, 32'h20, 1'b0);
        fetch(0, 32'h0000_0000);
        retire(C_BR, 1'b0, 32'h80, 32'h0, 32'h24, 1'b0);
        fetch(0, 32'h0000_0000);
        retire(C_NBR, 1'b0, 32'h20, 32'h0, 32'h20, 1'b0);

        // jr beats jmp, then misaligned jr halts
        fetch(0, 32'h0800_0100);
        retire(C_JR | C_JMP, 1'b0, 32'h0, 32'h40, 32'h40, 1'b0);
        fetch(0, 32'h0000_0000);
        retire(C_JR, 1'b0, 32'h0, 32'h42, 32'h0, 1'b1);
        imem_ready = 1'b1;
        advance    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("halt_req", {31'd0, imem_req}, 32'd0);
            check("halt_valid", {31'd0, instr_valid}, 32'd0);
            check("halt_fault", {31'd0, fault}, 32'd1);
        end

        // Reset out of halt, then reset in the middle of a wait
        do_reset(1);
        repeat (2) begin
            @(negedge clock);
            check("wait_req", {31'd0, imem_req}, 32'd1);
        end
        do_reset(1);

        // PC wrap from 0xFFFF_FFFC
        fetch(0, 32'h0000_0000);
        retire(C_JR, 1'b0, 32'h0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0);
        check("hi_addr", {18'd0, imem_addr}, 32'h3FFF);
        fetch(0, 32'h0000_0000);
        check("wrap_opc4", opcplus4, 32'h0);
        retire(C_NONE, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction-fetch stage of the 32-bit MIPS single-cycle core, directly upstream of the instruction decode / register-file stage. Holds the PC and fetches one instruction word at a time from instruction memory over a req/ready handshake. Presents `Instruction` and `opcplus4` to decode. Computes the next PC from branch, jump, jal and jr controls when the current instruction retires.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `ADDR_W`, 14, width of the word address driven to instruction memory.

Ports:
- `clock`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `imem_req`  out  1  fetch request to instruction memory.
- `imem_addr`  out  ADDR_W  word address; equals `PC[ADDR_W+1:2]`.
- `imem_ready`  in  1  memory has `imem_rdata` valid this cycle.
- `imem_rdata`  in  32  fetched instruction word.
- `Instruction`  out  32  registered instruction passed to decode.
- `opcplus4`  out  32  PC+4 of `Instruction`; the jal link value.
- `instr_valid`  out  1  `Instruction` and `opcplus4` are valid.
- `advance`  in  1  downstream retires the current instruction this cycle.
- `Branch`, `nBranch`, `Jmp`, `Jal`, `Jr`  in  1 each  control for the current instruction.
- `Zero`  in  1  ALU zero flag.
- `Addr_result`  in  32  branch target computed by execute.
- `Read_data_1`  in  32  rs value; the jr target.
- `fault`  out  1  sticky: a misaligned next-PC was detected.

## Operation
- FSM states:
  - S_FETCH: `imem_req`=1 and `imem_addr` from PC.
    - On `imem_ready`: capture `imem_rdata` into `Instruction` and PC+4 into `opcplus4`, then go to S_VALID.
  - S_VALID: `instr_valid`=1 and `imem_req`=0.
    - On `advance`: compute next PC. If aligned, load PC and go to S_FETCH.
    - If misaligned: set `fault` and go to S_HALT; PC is not updated.
  - S_HALT: `imem_req`=0 and `instr_valid`=0. Left only by reset.
- Next-PC priority, highest first:
  1. `Jr`: `Read_data_1`.
  2. `Jmp` or `Jal`: `{opcplus4[31:28], Instruction[25:0], 2'b00}`.
  3. Taken branch, where taken = `(Branch & Zero) | (nBranch & ~Zero)`: `Addr_result`.
  4. Otherwise `opcplus4`.
- Misaligned means next-PC bits [1:0] ≠ 0. This is only possible via jr or branch.
- PC+4 is computed modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- PC bits above ADDR_W+1 are kept in the PC but are not driven to memory.
- Control inputs are sampled only in a cycle where `instr_valid & advance`; otherwise they are ignored.

## Timing
- Reset values: PC = `RESET_PC`, state S_FETCH, `Instruction` = 0, `opcplus4` = 0, `instr_valid` = 0, `fault` = 0. `imem_req` is 0 during the reset cycle and 1 from the first cycle after reset.
- Fetch latency: `imem_ready` sampled high in cycle N → `instr_valid` = 1 in cycle N+1.
- `imem_addr` is stable for the whole time `imem_req` is high. `imem_ready` and `imem_rdata` are ignored when `imem_req` = 0.
- `Instruction` and `opcplus4` hold constant while `instr_valid` = 1. Decode writes r31 using `opcplus4` on the `advance` edge.
- `advance` in cycle N → `instr_valid` = 0 and `imem_req` = 1 in cycle N+1.
- Minimum period per instruction: 2 cycles, when memory is zero-wait (`imem_ready` high on the first request cycle).
- `advance` while `instr_valid` = 0 has no effect.
- Reset asserted in any state, including a pending fetch, aborts immediately and forces all reset values on the next edge.

## Structure
- Shared package `fetch_pkg` holds:
  - the state encoding enum (S_FETCH, S_VALID, S_HALT);
  - the `RESET_PC` default;
  - the jump-target field positions.
- One combinational sub-module, `fetch_next_pc`, takes the controls, `Zero`, `Addr_result`, `Read_data_1`, `Instruction` and `opcplus4`. It returns the 32-bit next PC and a misalign flag.
- The top-level module contains the FSM and the PC, `Instruction` and `opcplus4` registers.

## Test plan
- Reset, then memory with 3 wait cycles returning 32'h2008_0005 → `imem_addr` = 0 throughout the wait, `instr_valid` rises the cycle after ready, `opcplus4` = 32'h4.
- Sequential fetch: `advance` with no controls from PC 0x8 → next `imem_addr` = 3, `opcplus4` = 0x10.
- `Jal` with Instruction 32'h0C00_0040 at PC 0x0 → `opcplus4` stays 0x4 through the advance edge, next PC = 0x100.
- Branch cases:
  - `Branch`=1, `Zero`=1, `Addr_result`=0x20 → PC = 0x20.
  - `Branch`=1, `Zero`=0 → PC = PC+4.
  - `nBranch`=1, `Zero`=0 → PC = 0x20.
- `Jr` and `Jmp` both high with `Read_data_1` = 0x40 → PC = 0x40 (jr has priority). Then `Jr` with `Read_data_1` = 0x42 → `fault` = 1, state S_HALT, `imem_req` stays 0 until reset.
- Reset asserted mid-wait, and PC = 0xFFFF_FFFC with `advance` → all outputs return to reset values; PC wraps to 0 with no fault.
